imm_ext_pipe: RTL and testbench

- Parametrised, pipelined immediate-extension stage for the MIPS datapath; successor to the combinational sign/zero extender.
- Sits between decode and execute and extends an IN_W-bit immediate to OUT_W bits.
- Supports four modes: sign, zero, LUI-upper and branch-offset.
- Registered with a valid/ready handshake and a 2-entry skid buffer, so execute-stage backpressure never creates a combinational path to decode.

---
 rtl/imm_ext_pipe.sv | 157 +++++++++++++++
 tb/tb_imm_ext_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate extender, 2-entry skid, valid/ready.
// Optional IMMX_OPDECODE_EN derives the extension mode from the opcode.
module imm_ext_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [5:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] MODE_SIGN = 2'b00;
    localparam logic [1:0] MODE_ZERO = 2'b01;
    localparam logic [1:0] MODE_LUI  = 2'b10;
    localparam logic [1:0] MODE_BR   = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [OUT_W-1:0] or_imm_q, or_imm_d;
    logic [TAG_W-1:0] or_tag_q, or_tag_d;
    logic [OUT_W-1:0] sk_imm_q, sk_imm_d;
    logic [TAG_W-1:0] sk_tag_q, sk_tag_d;

    logic [1:0]       mode;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] ext_imm;
    logic             acc;
    logic             emit;

    // Both handshake outputs come straight from the state register.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_imm   = or_imm_q;
    assign out_tag   = or_tag_q;

    assign acc  = in_valid & in_ready;
    assign emit = out_valid & out_ready;

`ifdef IMMX_OPDECODE_EN
    logic is_lui;
    logic is_br;
    logic is_logic;

    assign is_lui   = (in_op == 6'b001111);
    assign is_br    = (in_op == 6'b000100) | (in_op == 6'b000101);
    assign is_logic = (in_op[3:2] == 2'b11) & ~is_lui;

    // Opcode decode: lui overlaps the logical-op pattern, so it is excluded.
    always_comb begin
        mode = MODE_SIGN;
        unique case (1'b1)
            is_lui:   mode = MODE_LUI;
            is_br:    mode = MODE_BR;
            is_logic: mode = MODE_ZERO;
            default:  mode = MODE_SIGN;
        endcase
    end
`else
    logic unused_op;

    assign unused_op = ^in_op;
    assign mode      = in_mode;
`endif

    // Extension arithmetic; OUT_W==IN_W degenerates cleanly (no shift).
    always_comb begin
        sext    = OUT_W'($signed(in_imm));
        zext    = OUT_W'(in_imm);
        ext_imm = sext;
        unique case (mode)
            MODE_SIGN: ext_imm = sext;
            MODE_ZERO: ext_imm = zext;
            MODE_LUI:  ext_imm = zext << (OUT_W - IN_W);
            MODE_BR:   ext_imm = sext << BR_SHIFT;
            default:   ext_imm = sext;
        endcase
    end

    // Occupancy FSM: OR always holds the oldest entry, SK the younger one.
    always_comb begin
        state_d  = state_q;
        or_imm_d = or_imm_q;
        or_tag_d = or_tag_q;
        sk_imm_d = sk_imm_q;
        sk_tag_d = sk_tag_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        or_imm_d = ext_imm;
                        or_tag_d = in_tag;
                        state_d  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && emit) begin
                        or_imm_d = ext_imm;
                        or_tag_d = in_tag;
                    end else if (acc) begin
                        sk_imm_d = ext_imm;
                        sk_tag_d = in_tag;
                        state_d  = ST_FULL;
                    end else if (emit) begin
                        state_d  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        or_imm_d = sk_imm_q;
                        or_tag_d = sk_tag_q;
                        state_d  = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State and data registers, cleared by asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            or_imm_q <= '0;
            or_tag_q <= '0;
            sk_imm_q <= '0;
            sk_tag_q <= '0;
        end else begin
            state_q  <= state_d;
            or_imm_q <= or_imm_d;
            or_tag_q <= or_tag_d;
            sk_imm_q <= sk_imm_d;
            sk_tag_q <= sk_tag_d;
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed and random checks of imm_ext_pipe
// against a queue-based reference model.
module tb_imm_ext_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int TAG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [5:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    logic [OUT_W-1:0] q_imm[$];
    logic [TAG_W-1:0] q_tag[$];
    logic [OUT_W-1:0] last_imm;
    logic [TAG_W-1:0] last_tag;

    imm_ext_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(2), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_op(in_op),
        .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] eff_mode(logic [1:0] m, logic [5:0] op);
`ifdef IMMX_OPDECODE_EN
        if (op == 6'd15) return 2'd2;
        if (op == 6'd4 || op == 6'd5) return 2'd3;
        if (op[3:2] == 2'b11) return 2'd1;
        return 2'd0;
`else
        if (op == 6'h3f) return m;
        return m;
`endif
    endfunction

    // Plain integer arithmetic on the numeric value of the immediate.
    function automatic logic [31:0] ref_ext(logic [15:0] imm, logic [1:0] m);
        longint u;
        longint s;
        longint r;
        u = longint'(imm);
        s = imm[15] ? u - 65536 : u;
        case (m)
            2'd0:    r = s;
            2'd1:    r = u;
            2'd2:    r = u * 65536;
            default: r = s * 4;
        endcase
        return r[31:0];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(string tag);
        logic ev;
        logic er;
        ev = (q_imm.size() > 0);
        er = (q_imm.size() < 2);
        chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, "_ready"}, 32'(in_ready), 32'(er));
        chk({tag, "_imm"}, out_imm, last_imm);
        chk({tag, "_tag"}, 32'(out_tag), 32'(last_tag));
    endtask

    task automatic drive(bit v, logic [15:0] imm, logic [1:0] m,
                         logic [5:0] op, logic [4:0] tg, bit ordy, bit fl);
        in_valid  = v;
        in_imm    = imm;
        in_mode   = m;
        in_op     = op;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic step(string tag);
        bit acc;
        bit emit;
        logic [31:0] e;
        acc  = in_valid && (q_imm.size() < 2);
        emit = (q_imm.size() > 0) && out_ready;
        e    = ref_ext(in_imm, eff_mode(in_mode, in_op));
        @(posedge clk);
        if (flush) begin
            q_imm.delete();
            q_tag.delete();
        end else begin
            if (emit) begin
                void'(q_imm.pop_front());
                void'(q_tag.pop_front());
            end
            if (acc) begin
                q_imm.push_back(e);
                q_tag.push_back(in_tag);
            end
        end
        if (q_imm.size() > 0) begin
            last_imm = q_imm[0];
            last_tag = q_tag[0];
        end
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [5:0] ops[6];
        ops = '{6'b001000, 6'b001101, 6'b001111,
                6'b000100, 6'b000101, 6'b100011};
        last_imm = '0;
        last_tag = '0;
        drive(0, 16'h0, 2'd0, 6'd0, 5'd0, 1, 0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        check_model("reset");
        rst_n = 1'b1;
        #2;

        drive(1, 16'h8001, 2'd0, 6'b001000, 5'd3, 1, 0);
        step("single");
        chk("single_const", out_imm, 32'hFFFF8001);
        drive(0, 16'h0, 2'd0, 6'b001000, 5'd0, 1, 0);
        step("single_gone");

        drive(1, 16'hF00F, 2'd1, 6'b001101, 5'd1, 1, 0);
        step("m_zero");
        chk("m_zero_const", out_imm, 32'h0000F00F);
        drive(1, 16'hF00F, 2'd2, 6'b001111, 5'd2, 1, 0);
        step("m_lui");
        chk("m_lui_const", out_imm, 32'hF00F0000);
        drive(1, 16'hF00F, 2'd3, 6'b000100, 5'd4, 1, 0);
        step("m_br");
        chk("m_br_const", out_imm, 32'hFFFFC03C);
        drive(0, 16'h0, 2'd0, 6'b001000, 5'd0, 1, 0);
        step("m_drain");

        drive(1, 16'd1, 2'd1, 6'b001101, 5'd10, 0, 0);
        step("bp_a");
        drive(1, 16'd2, 2'd1, 6'b001101, 5'd11, 0, 0);
        step("bp_b");
        chk("bp_full", 32'(in_ready), 32'd0);
        drive(0, 16'd0, 2'd1, 6'b001101, 5'd0, 0, 0);
        step("bp_hold");
        chk("bp_hold_a", out_imm, 32'd1);
        drive(0, 16'd0, 2'd1, 6'b001101, 5'd0, 1, 0);
        step("bp_emit_a");
        chk("bp_see_b", out_imm, 32'd2);
        step("bp_emit_b");

        drive(1, 16'd5, 2'd1, 6'b001101, 5'd5, 0, 0);
        step("fl_a");
        drive(1, 16'd6, 2'd1, 6'b001101, 5'd6, 0, 0);
        step("fl_b");
        drive(1, 16'd7, 2'd1, 6'b001101, 5'd7, 0, 1);
        step("fl_kill");
        drive(0, 16'd0, 2'd1, 6'b001101, 5'd0, 1, 0);
        step("fl_after1");
        step("fl_after2");

        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 16'($urandom), 2'($urandom),
                  ops[$urandom_range(0, 5)], 5'($urandom),
                  ($urandom % 3) != 0, ($urandom % 32) == 0);
            step("rand");
        end

        drive(1, 16'h1234, 2'd0, 6'b001000, 5'd9, 1, 0);
        step("ar_load");
        drive(0, 16'h0, 2'd0, 6'b001000, 5'd0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        q_imm.delete();
        q_tag.delete();
        last_imm = '0;
        last_tag = '0;
        check_model("ar_async");
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step("ar_idle1");
        step("ar_idle2");
        drive(1, 16'h0042, 2'd0, 6'b001000, 5'd8, 1, 0);
        step("ar_new");
        chk("ar_new_const", out_imm, 32'h00000042);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
